// File: rtl/soc_system_cc_pulse_out.sv
// Avalon-MM output port: static DATA bus plus timed inversion pulses.
// A pulse flips the masked bits for max(WIDTH,1) clocks, then raises done/irq.
module soc_system_cc_pulse_out #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_WIDTH  = 3'd1;
    localparam logic [2:0] A_TRIG   = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_OUTSET = 3'd4;
    localparam logic [2:0] A_OUTCLR = 3'd5;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    typedef enum logic {
        S_IDLE,
        S_PULSE
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_active;
    logic [CNT_WIDTH-1:0]  r_width;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_overrun;
    logic                  r_done;
    logic [31:0]           r_readdata;

    logic                  w_wr;
    logic                  w_busy;
    logic                  w_trig_wr;
    logic                  w_stat_wr;
    logic [DATA_WIDTH-1:0] w_wd;
    logic [31:0]           w_data32;
    logic [31:0]           w_mask32;
    logic [31:0]           w_width32;
    logic [31:0]           w_status32;

    assign w_wr      = chipselect && !write_n;
    assign w_trig_wr = w_wr && (address == A_TRIG);
    assign w_stat_wr = w_wr && (address == A_STATUS);
    assign w_wd      = writedata[DATA_WIDTH-1:0];
    assign w_busy    = (r_state == S_PULSE);

    // Zero-extend narrow registers onto the 32-bit read bus.
    always_comb begin
        w_data32                    = '0;
        w_data32[DATA_WIDTH-1:0]    = r_data;
        w_mask32                    = '0;
        w_mask32[DATA_WIDTH-1:0]    = r_active;
        w_width32                   = '0;
        w_width32[CNT_WIDTH-1:0]    = r_width;
        w_status32                  = '0;
        w_status32[2:0]             = {r_done, r_overrun, w_busy};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= RESET_VALUE[DATA_WIDTH-1:0];
            r_width <= '0;
        end else if (w_wr) begin
            case (address)
                A_DATA:   r_data  <= w_wd;
                A_WIDTH:  r_width <= writedata[CNT_WIDTH-1:0];
                A_OUTSET: r_data  <= r_data | w_wd;
                A_OUTCLR: r_data  <= r_data & ~w_wd;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            case (address)
                A_DATA:   r_readdata <= w_data32;
                A_WIDTH:  r_readdata <= w_width32;
                A_TRIG:   r_readdata <= w_mask32;
                A_STATUS: r_readdata <= w_status32;
                default:  r_readdata <= '0;
            endcase
        end
    end

    // Clears are applied first so a same-cycle set overrides them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_active  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (w_stat_wr) begin
                if (writedata[1]) r_overrun <= 1'b0;
                if (writedata[2]) r_done    <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_trig_wr && (w_wd != '0)) begin
                        r_active <= w_wd;
                        r_count  <= (r_width == '0) ? CNT_ONE : r_width;
                        r_state  <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (w_trig_wr) r_overrun <= 1'b1;
                    if (r_count == CNT_ONE) begin
                        r_active <= '0;
                        r_count  <= '0;
                        r_done   <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_count <= r_count - CNT_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_data ^ r_active;
    assign irq      = r_done;

endmodule

// File: tb/tb_soc_system_cc_pulse_out.sv
// Bench for soc_system_cc_pulse_out: read scoreboard plus
// cycle-accurate out_port pulse checks.
module tb_soc_system_cc_pulse_out;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_port;
    logic        irq;

    int n_run  = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic        rd_issue = 1'b0;

    soc_system_cc_pulse_out #(
        .DATA_WIDTH (32),
        .CNT_WIDTH  (16),
        .RESET_VALUE(32'h0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp,
                      input string tag);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        rd_issue   = 1'b1;
        @(negedge clk);
        rd_issue   = 1'b0;
        chipselect = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (rd_issue) begin
            if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else chk(tag_q.pop_front(), readdata, exp_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] base;
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        tick(2);
        reset = 1'b0;

        // reset state
        chk("rst_out", out_port, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        for (int a = 0; a < 8; a++) rd(3'(a), 32'h0, $sformatf("rst_rd%0d", a));
        chipselect = 1'b0;
        write_n    = 1'b0;
        address    = 3'd0;
        writedata  = 32'hDEAD_BEEF;
        tick();
        write_n    = 1'b1;
        rd(3'd0, 32'h0, "cs_low_ignored");
        wr(3'd6, 32'hFFFF_FFFF);
        rd(3'd6, 32'h0, "addr6_rd");

        // DATA / OUTSET / OUTCLR
        wr(3'd0, 32'hF0);
        chk("data_out", out_port, 32'hF0);
        wr(3'd4, 32'h1);
        chk("outset_out", out_port, 32'hF1);
        wr(3'd5, 32'h10);
        chk("outclr_out", out_port, 32'hE1);
        rd(3'd0, 32'hE1, "data_rb");

        // 5-clock pulse
        wr(3'd0, 32'h0);
        wr(3'd1, 32'd5);
        rd(3'd1, 32'd5, "width_rb");
        chk("t3_pre", out_port, 32'h0);
        wr(3'd2, 32'h3);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_pulse%0d", i), out_port, 32'h3);
            if (i == 1) rd(3'd3, 32'h1, "t3_busy");
            else if (i == 2) rd(3'd2, 32'h3, "t3_mask");
            else tick();
        end
        chk("t3_end", out_port, 32'h0);
        rd(3'd3, 32'h4, "t3_done");
        chk("t3_irq", {31'd0, irq}, 32'h1);
        wr(3'd3, 32'h4);
        chk("t3_irq_clr", {31'd0, irq}, 32'h0);
        rd(3'd3, 32'h0, "t3_st_clr");

        // WIDTH=0 gives a one-clock pulse
        wr(3'd1, 32'd0);
        wr(3'd2, 32'h80);
        chk("t4_pulse", out_port, 32'h80);
        tick();
        chk("t4_end", out_port, 32'h0);
        rd(3'd3, 32'h4, "t4_done");
        wr(3'd3, 32'h4);

        // zero-mask trigger in IDLE does nothing
        wr(3'd2, 32'h0);
        chk("zmask_out", out_port, 32'h0);
        rd(3'd3, 32'h0, "zmask_st");

        // overrun plus DATA update mid-pulse
        wr(3'd1, 32'd10);
        wr(3'd2, 32'h1);
        base = 32'h0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t5_pulse%0d", i), out_port, base ^ 32'h1);
            if (i == 2) wr(3'd2, 32'h2);
            else if (i == 5) begin
                wr(3'd4, 32'h100);
                base = 32'h100;
            end else tick();
        end
        chk("t5_end", out_port, 32'h100);
        rd(3'd3, 32'h6, "t5_st");
        wr(3'd3, 32'h2);
        rd(3'd3, 32'h4, "t5_w1c_ovr");
        wr(3'd3, 32'h4);
        wr(3'd0, 32'h0);

        // trigger in the same cycle the pulse ends is an overrun
        wr(3'd1, 32'd1);
        wr(3'd2, 32'h1);
        wr(3'd2, 32'h2);
        chk("end_trig_out", out_port, 32'h0);
        rd(3'd3, 32'h6, "end_trig_st");
        wr(3'd3, 32'h6);

        // done set beats same-cycle W1C
        wr(3'd2, 32'h1);
        wr(3'd3, 32'h4);
        rd(3'd3, 32'h4, "set_wins");
        wr(3'd3, 32'h4);

        // reset mid-pulse
        wr(3'd1, 32'd8);
        wr(3'd2, 32'hFF);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t6_pulse%0d", i), out_port, 32'hFF);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_out", out_port, 32'h0);
        chk("t6_rst_irq", {31'd0, irq}, 32'h0);
        rd(3'd3, 32'h0, "t6_rst_st");
        rd(3'd1, 32'h0, "t6_rst_width");
        wr(3'd1, 32'd2);
        wr(3'd2, 32'h5);
        chk("t6_again0", out_port, 32'h5);
        tick();
        chk("t6_again1", out_port, 32'h5);
        tick();
        chk("t6_again_end", out_port, 32'h0);
        rd(3'd3, 32'h4, "t6_again_done");

        tick(2);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
